// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit, signed or unsigned, with HI/LO results.
// It computes one result bit per cycle and uses a start/ready handshake with annul.
module iter_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             annul,
  input  logic             op,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned RW    = WIDTH + 1;
  localparam int unsigned SW    = WIDTH + 2;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_q, op_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   mag_a, mag_b, quot, remv;
  logic [SW-1:0]      rem_sh;
  logic               rem_ge;
  logic [RW-1:0]      add_sum;
  logic [PW-1:0]      prod;
  logic               neg_res;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    b_zero_d = b_zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ready_d  = 1'b0;

    mag_a   = (sign && a[WIDTH-1]) ? WIDTH'(-a) : a;
    mag_b   = (sign && b[WIDTH-1]) ? WIDTH'(-b) : b;
    // Restoring divide step: shift next dividend bit into the partial remainder.
    rem_sh  = {rem_q, acc_q[WIDTH-1]};
    rem_ge  = (rem_sh >= SW'(opnd_q));
    add_sum = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : RW'(0));
    neg_res = a_neg_q ^ b_neg_q;
    prod    = neg_res ? PW'(-acc_q) : acc_q;
    quot    = neg_res ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    remv    = a_neg_q ? WIDTH'(-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
    if (b_zero_q) quot = '1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          cnt_d    = '0;
          acc_d    = {WIDTH'(0), mag_a};
          rem_d    = '0;
          opnd_d   = mag_b;
          op_d     = op;
          a_neg_d  = sign & a[WIDTH-1];
          b_neg_d  = sign & b[WIDTH-1];
          b_zero_d = (b == '0);
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q) begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {acc_q[PW-1:WIDTH], acc_q[WIDTH-2:0], rem_ge};
          rem_d = rem_ge ? RW'(rem_sh - SW'(opnd_q)) : RW'(rem_sh);
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = SIGN;
      end
      SIGN: begin
        state_d = DONE;
        ready_d = 1'b1;
        if (op_q) begin
          hi_d = prod[PW-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          hi_d = remv;
          lo_d = quot;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Annul wins in every state and discards any result in flight.
    if (annul) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      ready_d = 1'b0;
    end
    busy_d = (state_d == CALC) || (state_d == SIGN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      op_q     <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      b_zero_q <= b_zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Scoreboard bench for iter_muldiv: a 32-bit instance checked against a reference model
// and against fixed vectors, plus an 8-bit instance for the overflow and reset cases.
module tb_iter_muldiv;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst, start, annul, op, sign;
  logic [31:0] a, b, hi, lo;
  logic        ready, busy;

  logic        rst8, start8, annul8, op8, sign8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        ready8, busy8;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  iter_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .annul(annul), .op(op), .sign(sign),
    .a(a), .b(b), .hi(hi), .lo(lo), .ready(ready), .busy(busy)
  );

  iter_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .annul(annul8), .op(op8), .sign(sign8),
    .a(a8), .b(b8), .hi(hi8), .lo(lo8), .ready(ready8), .busy(busy8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic o, input logic s,
                                        input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] px, py;
    logic signed [31:0] sx, sy;
    if (o) begin
      if (s) begin
        px = $signed({{32{x[31]}}, x});
        py = $signed({{32{y[31]}}, y});
        return 64'(px * py);
      end
      return {32'b0, x} * {32'b0, y};
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sx = x;
      sy = y;
      return {32'(sx % sy), 32'(sx / sy)};
    end
    return {x % y, x / y};
  endfunction

  // Every ready pulse must match the oldest outstanding expectation, in value and cycle.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("ready_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic issue(input logic o, input logic s, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    @(negedge clk);
    op = o; sign = s; a = ia; b = ib; start = 1'b1;
    e.hi = ehi; e.lo = elo; e.cyc = cyc + W + 2;
    sb.push_back(e);
    last_hi = ehi; last_lo = elo;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = ~o; sign = ~s;
  endtask

  task automatic issue_m(input logic o, input logic s, input logic [31:0] ia, input logic [31:0] ib);
    logic [63:0] r;
    r = model(o, s, ia, ib);
    issue(o, s, ia, ib, r[63:32], r[31:0]);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    if (!seen) check("ready_timeout", 0, 1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        seen8;
    int          c0;
    rst = 1'b1; start = 0; annul = 0; op = 0; sign = 0; a = '0; b = '0;
    rst8 = 1'b1; start8 = 0; annul8 = 0; op8 = 0; sign8 = 0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; rst8 = 1'b0;

    // Unsigned 100/7 with busy traced cycle by cycle (k = cycles after start cycle).
    issue(1'b0, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    check("busy_k1", busy, 1);
    for (int k = 2; k <= W + 3; k++) begin
      @(negedge clk);
      check($sformatf("busy_k%0d", k), busy, (k <= W + 1) ? 1 : 0);
    end

    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done();
    issue(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    wait_done();
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done();
    issue(1'b0, 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    wait_done();
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    wait_done();
    issue(1'b0, 1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
    wait_done();

    // Annul during CALC: no result, busy drops, hi/lo untouched.
    @(negedge clk);
    op = 0; sign = 0; a = 32'd50; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    check("annul_busy", busy, 0);
    repeat (40) @(negedge clk);
    check("annul_hi", hi, last_hi);
    check("annul_lo", lo, last_lo);

    // New op after annul; a start mid-operation must be ignored.
    issue(1'b0, 1'b0, 32'd9, 32'd3, 32'd0, 32'd3);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd77; b = 32'd11;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start together with annul in IDLE does nothing.
    @(negedge clk);
    start = 1'b1; annul = 1'b1; op = 1'b1; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    check("start_annul_busy", busy, 0);
    repeat (40) @(negedge clk);
    check("start_annul_lo", lo, last_lo);

    // Randomised back-to-back operations with boundary operands mixed in.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 8)
        1: rb = 32'd0;
        2: rb = 32'd1;
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4: rb = rb >> 24;
        default: ;
      endcase
      issue_m(1'(i % 2), 1'($urandom_range(0, 1)), ra, rb);
      wait_done();
    end

    // 8-bit instance: signed 0x80 / 0xFF, ready exactly at n+10.
    @(negedge clk);
    op8 = 0; sign8 = 1; a8 = 8'h80; b8 = 8'hFF; start8 = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h3C; b8 = 8'h05;
    seen8 = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (ready8) begin
        seen8 = 1'b1;
        check("w8_ready_cycle", cyc, c0 + 9);
        check("w8_lo", lo8, 8'h80);
        check("w8_hi", hi8, 8'h00);
      end
      @(negedge clk);
    end
    if (!seen8) check("w8_ready_timeout", 0, 1);

    // Reset mid-CALC clears outputs immediately and suppresses the result.
    @(negedge clk);
    op8 = 1; sign8 = 0; a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    #1;
    check("w8_rst_hi", hi8, 0);
    check("w8_rst_lo", lo8, 0);
    check("w8_rst_busy", busy8, 0);
    @(negedge clk);
    rst8 = 1'b0;
    seen8 = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ready8) seen8 = 1'b1;
    end
    check("w8_no_ready_after_rst", seen8, 0);
    check("w8_rst_lo_hold", lo8, 0);

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iter_muldiv.md
# iter_muldiv

Parametrised iterative multiply/divide unit for the execute stage of the pipelined MIPS core. It replaces the fixed 32-bit divider with one engine that handles both multiply and divide, signed and unsigned, at a configurable operand width. The unit uses a start/ready handshake with annul, so the hazard unit can stall the pipeline while the unit is busy and cancel an operation on a flush. Results follow the HI/LO convention: division writes the remainder to HI and the quotient to LO; multiplication writes the upper product half to HI and the lower half to LO.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 4.
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- annul  in  1  cancel the current or pending operation; sampled in every state.
- op  in  1  operation select, 0 = divide, 1 = multiply; captured with start.
- sign  in  1  operand type, 1 = signed (two's complement), 0 = unsigned; captured with start.
- a  in  WIDTH  dividend or multiplicand; captured with start.
- b  in  WIDTH  divisor or multiplier; captured with start.
- hi  out  WIDTH  remainder (divide) or product[2W-1:W] (multiply); registered.
- lo  out  WIDTH  quotient (divide) or product[W-1:0] (multiply); registered.
- ready  out  1  one-cycle pulse: hi/lo hold a new result.
- busy  out  1  high while in CALC or SIGN.

## Operation
- Reset values: state IDLE, hi = 0, lo = 0, ready = 0, busy = 0, iteration counter = 0.
- States:
  - IDLE → CALC on start & ~annul. At this transition the unit latches op, sign, the operand signs, and |a|, |b| (magnitudes when sign = 1, raw values otherwise). The counter clears.
  - CALC: one iteration per edge.
    - Divide: restoring shift-subtract, one quotient bit per cycle.
    - Multiply: shift-add, one multiplier bit per cycle.
    - After WIDTH iterations, go to SIGN.
  - SIGN: sign-correct the magnitude result and register it into hi/lo. Go to DONE.
  - DONE: ready = 1. Go to IDLE unconditionally.
- Sign rules when sign = 1:
  - Quotient is negated if sign(a) ≠ sign(b).
  - Remainder takes the sign of a.
  - Product is negated (2W-bit two's complement) if sign(a) ≠ sign(b).
- Overflow case: signed divide of −2^(W−1) by −1 gives lo = −2^(W−1) (wraps) and hi = 0. There is no trap.
- Divide by zero (b = 0, either sign mode): lo = all ones, hi = raw a. The full latency still applies.
- Operand inputs are ignored after capture. They may change freely while the unit is busy.
- start is ignored in CALC, SIGN and DONE. It is not queued.
- annul = 1 in any state forces IDLE at the next edge.
  - ready is not asserted and hi/lo keep their previous values.
  - annul together with start in IDLE: the unit stays in IDLE.
- hi/lo change only on the SIGN → DONE edge. They hold that value until the next completed operation.
- Internal widths:
  - Divide partial remainder: WIDTH+1 bits.
  - Multiply accumulator: 2·WIDTH bits.
  - Counter: clog2(WIDTH+1) bits.

## Timing
- If start is sampled at edge 0 (cycle n):
  - CALC occupies the cycles after edges 0 through WIDTH−1.
  - SIGN follows edge WIDTH.
  - ready is high in cycle n+WIDTH+2, which is cycle n+34 for WIDTH = 32.
- busy:
  - Rises in cycle n+1.
  - Falls in the DONE cycle (n+WIDTH+2).
  - Falls in the cycle after an annul edge.
- Earliest back-to-back operation: start is sampled in the cycle after DONE, giving a throughput of one operation per WIDTH+3 cycles.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). No ready pulse follows.
- Outputs are registered or decoded directly from state. There is no combinational path from the inputs to any output.

## Test plan
- Unsigned divide, WIDTH = 32: a = 100, b = 7, start at cycle n → ready only in n+34 with lo = 14, hi = 2; busy high for n+1..n+33.
- Signed divide and multiply:
  - a = −7, b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - a = −3, b = 5 multiply → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- Unsigned multiply 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- Divide by zero: a = 0x12345678, b = 0, signed → lo = 0xFFFFFFFF, hi = 0x12345678, ready at n+34.
- Annul at n+10 of a divide:
  - Check busy = 0 at n+11, no ready pulse, and hi/lo unchanged.
  - Then issue a new start with 9/3 → lo = 3, hi = 0, ready 34 cycles later.
  - Also check start ignored while busy and start & annul in IDLE ignored.
- WIDTH = 8, signed 0x80 / 0xFF → lo = 0x80, hi = 0x00, ready at n+10; rst pulse mid-CALC → hi = lo = 0, no ready.
